uart_rx_parity: RTL and testbench

UART_RX_PARITY -- requirements
Module: uart_rx_parity

---
 rtl/uart_rx_parity.sv | 157 +++++++++++++++
 tb/tb_uart_rx_parity.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_parity.sv
// uart_rx_parity: 8-bit UART receiver with optional parity checking and a
// single-entry valid/ready holding register for the received byte.
//
// state  | meaning
// IDLE   | line idle; a falling edge (once armed) starts a frame
// START  | timing to mid start bit; line high there is a glitch, drop it
// DATA   | sampling 8 data bits, LSB first, one per bit time
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit; the byte is delivered on this sample
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx_parity #(
    parameter int CLKS_PER_BIT = 5210,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    localparam logic PAR_EN  = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_s_q;
    logic [1:0]      flush_q;
    logic            armed_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            par_bit_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q, parity_err_q, frame_err_q, overrun_q;
    logic            tc, data_smp, par_smp, stop_smp, par_mismatch;

    assign tc = (cnt_q == '0);
    assign par_mismatch = PAR_EN && ((^shift_q ^ par_bit_q) != PAR_ODD);

    // Two-flop synchronizer; idle-high reset value so reset never looks like a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Arm start detection only after the synchronizer has flushed and the line was seen high,
    // so a line held low through reset cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            if (flush_q != 2'd2) flush_q <= flush_q + 2'd1;
            if (flush_q == 2'd2 && rx_s_q) armed_q <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (armed_q && !rx_s_q) state_d = S_START;
            S_START:  if (tc) state_d = rx_s_q ? S_IDLE : S_DATA;
            S_DATA:   if (tc && bit_idx_q == 3'd7) state_d = PAR_EN ? S_PARITY : S_STOP;
            S_PARITY: if (tc) state_d = S_STOP;
            S_STOP:   if (tc) state_d = rx_s_q ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx_s_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and per-bit sample strobes.
    always_comb begin
        busy     = (state_q != S_IDLE);
        data_smp = (state_q == S_DATA)   && tc;
        par_smp  = (state_q == S_PARITY) && tc;
        stop_smp = (state_q == S_STOP)   && tc;
    end

    // Bit timer (down-counter, reloads each bit), bit index and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            par_bit_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q     <= HALF_M1;
                    bit_idx_q <= 3'd0;
                end
                S_START, S_DATA, S_PARITY, S_STOP:
                    cnt_q <= tc ? BIT_M1 : cnt_q - CW'(1);
                default: cnt_q <= '0;
            endcase
            if (data_smp) begin
                shift_q   <= {rx_s_q, shift_q[7:1]};
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (par_smp) par_bit_q <= rx_s_q;
        end
    end

    // Output holding register: load on stop sample, clear on accept, flag overwrite.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (stop_smp) begin
                rx_data_q    <= shift_q;
                parity_err_q <= par_mismatch;
                frame_err_q  <= !rx_s_q;
                rx_valid_q   <= 1'b1;
                overrun_q    <= rx_valid_q && !rx_ready;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_parity.sv
// Bench for uart_rx_parity: an even-parity and an odd-parity receiver share one
// line; accepted bytes are compared against an expectation queue.
module tb_uart_rx_parity;

    localparam int C = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic rx_ready = 1'b1;

    logic [7:0] rx_data, rx_data_o;
    logic rx_valid, parity_err, frame_err, overrun, busy;
    logic rx_valid_o, parity_err_o, frame_err_o, overrun_o, busy_o;

    always #5 clk = ~clk;

    uart_rx_parity #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    uart_rx_parity #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data_o), .rx_valid(rx_valid_o),
        .rx_ready(rx_ready), .parity_err(parity_err_o), .frame_err(frame_err_o),
        .overrun(overrun_o), .busy(busy_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       perr_e;
        logic       perr_o;
        logic       ferr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr_e;
        logic       perr_o;
        logic       ferr;
    } exp_t;

    localparam int NV = 8;
    vec_t vecs[NV];
    exp_t exp_q[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;
    int rise_cnt = 0;
    int ovr_cnt = 0;
    logic valid_prev = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(C);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic po, input logic fe);
        exp_t e;
        e.data = d; e.perr_e = pe; e.perr_o = po; e.ferr = fe;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input vec_t v, input int gap_bits);
        push_exp(v.data, v.perr_e, v.perr_o, v.ferr);
        drive_frame(v.data, v.par, v.stop);
        if (!v.stop) begin
            rx = 1'b0;
            tick(3 * C);
        end
        rx = 1'b1;
        tick(gap_bits * C);
    endtask

    // Scoreboard: compare each accepted byte; count valid rises and overrun pulses.
    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (rx_valid && !valid_prev) rise_cnt++;
        valid_prev = rx_valid;
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL sb_unexpected: got byte 0x%0h expected no byte", rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_data", rx_data, mon_e.data);
                check("sb_perr_even", parity_err, mon_e.perr_e);
                check("sb_perr_odd", parity_err_o, mon_e.perr_o);
                check("sb_ferr", frame_err, mon_e.ferr);
                check("sb_odd_valid", rx_valid_o, 1);
            end
        end
    end

    initial begin
        int r0;
        int o0;
        logic [7:0] b;

        vecs[0] = '{8'h09, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h09, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h6E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; rx = 1'b1; rx_ready = 1'b1;
        tick(4);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < NV; i++) send_frame(vecs[i], 2);

        // Framing error with line held low: one delivery, busy until line high.
        r0 = rise_cnt;
        push_exp(8'hA5, 1'b0, 1'b1, 1'b1);
        drive_frame(8'hA5, 1'b0, 1'b0);
        rx = 1'b0;
        tick(3 * C);
        check("break_busy", busy, 1);
        check("break_one_delivery", rise_cnt - r0, 1);
        rx = 1'b1;
        tick(4);
        check("break_exit_busy", busy, 0);
        tick(2 * C);
        check("break_no_second", rise_cnt - r0, 1);

        // Short low glitch: start detected, rejected at mid start bit.
        r0 = rise_cnt;
        rx = 1'b0;
        tick(C / 4);
        check("glitch_busy_seen", busy, 1);
        rx = 1'b1;
        tick(C / 2 + 3 - C / 4);
        check("glitch_idle", busy, 0);
        tick(2 * C);
        check("glitch_no_valid", rise_cnt - r0, 0);

        // Back-to-back frames with consumer stalled: second overwrites, one overrun.
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        push_exp(8'h22, 1'b0, 1'b1, 1'b0);
        drive_frame(8'h11, 1'b0, 1'b1);
        check("ovr_first_valid", rx_valid, 1);
        check("ovr_first_data", rx_data, 8'h11);
        drive_frame(8'h22, 1'b0, 1'b1);
        rx = 1'b1;
        tick(2 * C);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_data", rx_data, 8'h22);
        check("ovr_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        tick(1);
        check("ovr_valid_clear", rx_valid, 0);
        tick(C);

        // Reset during data bit 4 of 0x3C aborts the frame.
        r0 = rise_cnt;
        b = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        tick(C / 2);
        rst = 1'b1;
        tick(2);
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_ferr", frame_err, 0);
        rst = 1'b0;
        rx = 1'b1;
        tick(3 * C);
        check("midrst_idle", busy, 0);
        check("midrst_no_valid", rise_cnt - r0, 0);
        send_frame('{8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 2);

        // Line held low across reset must not start a frame.
        r0 = rise_cnt;
        rx = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3 * C);
        check("lowrst_busy", busy, 0);
        check("lowrst_no_valid", rise_cnt - r0, 0);
        rx = 1'b1;
        tick(2 * C);
        send_frame('{8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, 2);

        tick(C);
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
